fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, imem handshake FSM and the IF/ID pipeline register.
// Define FETCH_CTRL_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counter outputs.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_pc_src,
  input  logic [31:0] ex_mem_npc,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_plus4;
  logic [31:0] buf_instr, buf_instr_nxt;
  logic [31:0] buf_npc, buf_npc_nxt;
  logic [31:0] if_id_instr_nxt, if_id_npc_nxt;
  logic        if_id_valid_nxt;

  assign pc_plus4  = pc + 32'd4;
  // Both outputs come straight from registers, so a redirect reaches memory one edge later.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  // NOTE: every variable is defaulted to its held value first, so no path through the case infers a latch.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    buf_instr_nxt   = buf_instr;
    buf_npc_nxt     = buf_npc;
    if_id_instr_nxt = if_id_instr;
    if_id_npc_nxt   = if_id_npc;
    if_id_valid_nxt = if_id_valid;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_ack) begin
          pc_nxt = pc_plus4;
          if (id_stall) begin
            buf_instr_nxt = imem_rdata;
            buf_npc_nxt   = pc_plus4;
            state_nxt     = HOLD;
          end else begin
            if_id_instr_nxt = imem_rdata;
            if_id_npc_nxt   = pc_plus4;
            if_id_valid_nxt = 1'b1;
          end
        end else if (!id_stall) begin
          if_id_instr_nxt = NOP_INSTR;
          if_id_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (!id_stall) begin
          if_id_instr_nxt = buf_instr;
          if_id_npc_nxt   = buf_npc;
          if_id_valid_nxt = 1'b1;
          state_nxt       = REQ;
        end
      end
      DRAIN: if (imem_ack) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase

    // Redirect overrides everything above; an unanswered request must be drained first.
    if (ex_mem_pc_src) begin
      pc_nxt          = ex_mem_npc;
      if_id_instr_nxt = NOP_INSTR;
      if_id_npc_nxt   = 32'h0;
      if_id_valid_nxt = 1'b0;
      state_nxt       = ((state == REQ || state == DRAIN) && !imem_ack) ? DRAIN : REQ;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      buf_instr   <= NOP_INSTR;
      buf_npc     <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_npc   <= 32'h0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      buf_instr   <= buf_instr_nxt;
      buf_npc     <= buf_npc_nxt;
      if_id_instr <= if_id_instr_nxt;
      if_id_npc   <= if_id_npc_nxt;
      if_id_valid <= if_id_valid_nxt;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic fetch_load;
  logic stall_cycle;

  assign fetch_load  = !ex_mem_pc_src && !id_stall &&
                       ((state == REQ && imem_ack) || state == HOLD);
  assign stall_cycle = (imem_req && !imem_ack) || (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (fetch_load)  perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_cycle) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; inputs change 1ns after each rising edge, outputs are checked there.
module tb_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_pc_src;
  logic [31:0] ex_mem_npc;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_pc_src(ex_mem_pc_src), .ex_mem_npc(ex_mem_npc),
    .id_stall(id_stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_npc(if_id_npc), .if_id_valid(if_id_valid)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic stall,
                       input logic src, input logic [31:0] npc);
    imem_ack      = ack;
    imem_rdata    = rdata;
    id_stall      = stall;
    ex_mem_pc_src = src;
    ex_mem_npc    = npc;
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] instr,
                             input logic [31:0] npc, input logic valid);
    check({tag, ".instr"}, if_id_instr, instr);
    check({tag, ".npc"},   if_id_npc,   npc);
    check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, valid});
  endtask

  task automatic expect_fetch(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"},  {31'h0, imem_req}, {31'h0, req});
    check({tag, ".addr"}, imem_addr, addr);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    expect_fetch("reset", 1'b0, 32'h0);
    expect_ifid("reset", NOP, 32'h0, 1'b0);

    // Reset release: one IDLE cycle, then REQ at pc 0 with same-cycle acks.
    rst = 1'b0;
    #1 expect_fetch("idle", 1'b0, 32'h0);
    tick();
    expect_fetch("req0", 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, word(32'(i * 4)), 1'b0, 1'b0, 32'h0);
      tick();
      expect_fetch($sformatf("seq%0d", i), 1'b1, 32'(i * 4 + 4));
      expect_ifid($sformatf("seq%0d", i), word(32'(i * 4)), 32'(i * 4 + 4), 1'b1);
    end

    // Reset mid-request, with an ack arriving while no request is pending.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    #1 expect_fetch("rst_mid", 1'b0, 32'h0);
    expect_ifid("rst_mid", NOP, 32'h0, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    expect_fetch("stale_ack", 1'b1, 32'h0);
    expect_ifid("stale_ack", NOP, 32'h0, 1'b0);
    drive(1'b1, word(32'h0), 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, word(32'h4), 1'b0, 1'b0, 32'h0);
    tick();
    expect_ifid("refetch4", word(32'h4), 32'h8, 1'b1);
    expect_fetch("refetch4", 1'b1, 32'h8);

    // Two wait states at pc 8.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    expect_fetch("wait1", 1'b1, 32'h8);
    expect_ifid("wait1", NOP, 32'h8, 1'b0);
    tick();
    expect_fetch("wait2", 1'b1, 32'h8);
    check("wait2.valid", {31'h0, if_id_valid}, 32'h0);
    drive(1'b1, word(32'h8), 1'b0, 1'b0, 32'h0);
    tick();
    expect_fetch("wait_ack", 1'b1, 32'hC);
    expect_ifid("wait_ack", word(32'h8), 32'hC, 1'b1);

    // Decode stall for three cycles while the ack for pc 12 arrives.
    drive(1'b1, word(32'hC), 1'b1, 1'b0, 32'h0);
    tick();
    expect_fetch("hold1", 1'b0, 32'h10);
    expect_ifid("hold1", word(32'h8), 32'hC, 1'b1);
    drive(1'b1, 32'hBAD0_0001, 1'b1, 1'b0, 32'h0);
    tick();
    tick();
    expect_fetch("hold3", 1'b0, 32'h10);
    expect_ifid("hold3", word(32'h8), 32'hC, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    expect_fetch("unhold", 1'b1, 32'h10);
    expect_ifid("unhold", word(32'hC), 32'h10, 1'b1);

    // Redirect with no ack: drain the late response, then fetch at 0x100.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    tick();
    expect_fetch("drain", 1'b0, 32'h100);
    expect_ifid("flush", NOP, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    expect_fetch("drain_wait", 1'b0, 32'h100);
    drive(1'b1, 32'hBAD0_0002, 1'b0, 1'b0, 32'h0);
    tick();
    expect_fetch("drain_ack", 1'b1, 32'h100);
    expect_ifid("drain_ack", NOP, 32'h0, 1'b0);
    drive(1'b1, word(32'h100), 1'b0, 1'b0, 32'h0);
    tick();
    expect_ifid("post_drain", word(32'h100), 32'h104, 1'b1);

    // Redirect with ack in REQ to 0x20, then redirect+ack+stall at 0x20 to 0x40.
    drive(1'b1, 32'hBAD0_0003, 1'b0, 1'b1, 32'h20);
    tick();
    expect_fetch("redir_ack", 1'b1, 32'h20);
    expect_ifid("redir_ack", NOP, 32'h0, 1'b0);
    drive(1'b1, 32'hBAD0_0004, 1'b1, 1'b1, 32'h40);
    tick();
    expect_fetch("redir_all", 1'b1, 32'h40);
    expect_ifid("redir_all", NOP, 32'h0, 1'b0);
    drive(1'b1, word(32'h40), 1'b0, 1'b0, 32'h0);
    tick();
    expect_ifid("after_all", word(32'h40), 32'h44, 1'b1);

    // Second redirect while draining overwrites the target.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    tick();
    expect_fetch("drain_redir", 1'b0, 32'h300);
    drive(1'b1, 32'hBAD0_0005, 1'b0, 1'b0, 32'h0);
    tick();
    expect_fetch("drain_redir_ack", 1'b1, 32'h300);

    // PC wraps modulo 2^32.
    drive(1'b1, 32'hBAD0_0006, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, word(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0);
    tick();
    expect_fetch("wrap", 1'b1, 32'h0);
    expect_ifid("wrap", word(32'hFFFF_FFFC), 32'h0, 1'b1);

    // Redirect in HOLD discards the buffered word.
    drive(1'b1, 32'hBAD0_0007, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h80);
    tick();
    expect_fetch("hold_redir", 1'b1, 32'h80);
    expect_ifid("hold_redir", NOP, 32'h0, 1'b0);
    drive(1'b1, word(32'h80), 1'b0, 1'b0, 32'h0);
    tick();
    expect_ifid("hold_redir_next", word(32'h80), 32'h84, 1'b1);

`ifdef FETCH_CTRL_PERF_EN
    // Five fetches and two wait cycles from a fresh reset.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    check("perf_rst.fetch", perf_fetch_cnt, 32'd0);
    check("perf_rst.stall", perf_stall_cnt, 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      drive((i == 2 || i == 3) ? 1'b0 : 1'b1, 32'h1234_0000, 1'b0, 1'b0, 32'h0);
      tick();
    end
    check("perf.fetch", perf_fetch_cnt, 32'd5);
    check("perf.stall", perf_stall_cnt, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
